edge_detector_mc: RTL
=====================

Name: edge_detector_mc

Overview:
Multi-channel, parametrised edge detector for asynchronous or noisy level inputs such as pins, status lines and cross-domain flags. Each channel has three stages in series: a synchroniser chain, a stability (glitch) filter, and rise/fall edge detection. Outputs per channel are single-cycle edge pulses, the filtered level and a sticky per-channel event flag. An OR of all pending flags drives an interrupt line for the local CSR/interrupt block.

Parameters:
NUM_CH, 8, number of independent channels (>=1)
SYNC_STAGES, 2, synchroniser flops per channel (>=1)
FILTER_CYCLES, 4, consecutive cycles a new synchronised value must hold before the filtered level changes (>=1)
CNT_W, 8, event-counter width; used only when EDGE_DET_EVENT_CNT_EN is defined

Ports:
CLK  input  1  clock
RSTN  input  1  asynchronous active-low reset
SAMPLE_IN  input  NUM_CH  raw channel inputs, may be asynchronous to CLK
RISE_EN  input  NUM_CH  per-channel enable for rise events into EVENT_PENDING
FALL_EN  input  NUM_CH  per-channel enable for fall events into EVENT_PENDING
EVENT_CLEAR  input  NUM_CH  per-channel clear of EVENT_PENDING, 1-cycle strobe or level
LEVEL_OUT  output  NUM_CH  filtered, debounced level
RISE_EDGE_OUT  output  NUM_CH  one-cycle pulse on filtered 0->1
FALL_EDGE_OUT  output  NUM_CH  one-cycle pulse on filtered 1->0
EVENT_PENDING  output  NUM_CH  sticky event flags
IRQ_OUT  output  1  OR-reduction of EVENT_PENDING

Behaviour:
- Reset: asynchronous assertion on RSTN low, synchronous-to-CLK release.
- While RSTN is low, all flops are cleared: synchroniser chain, filter counter, level, previous-level register and pending flags.
- Reset values: LEVEL_OUT=0, RISE_EDGE_OUT=0, FALL_EDGE_OUT=0, EVENT_PENDING=0, IRQ_OUT=0.
- Asserting reset mid-operation clears everything immediately. No pulse is generated by the reset itself.
- Synchroniser: SAMPLE_IN[i] shifts through SYNC_STAGES flops. sync[i] is the last stage.
- Filter, per channel, one counter of width clog2(FILTER_CYCLES), minimum 1 bit:
  - sync==level: counter <= 0.
  - sync!=level and counter==FILTER_CYCLES-1: level <= sync, counter <= 0.
  - otherwise: counter <= counter+1.
  - A sync deviation lasting fewer than FILTER_CYCLES cycles never changes level.
  - FILTER_CYCLES=1: level follows sync one cycle later.
- Edge detection: a prev register samples level every cycle.
  - RISE_EDGE_OUT = level & ~prev; FALL_EDGE_OUT = ~level & prev. Both are decoded from flops only, with no combinational path from SAMPLE_IN.
  - Each pulse lasts exactly 1 cycle. Rise and fall are never asserted together on the same channel.
- Latency: count the first CLK edge that samples the new SAMPLE_IN as edge 1. LEVEL_OUT and the edge pulse assert after edge SYNC_STAGES+FILTER_CYCLES. With defaults this is after edge 6.
- Minimum spacing between two pulses on a channel is FILTER_CYCLES cycles.
- Pending flags:
  - set condition: (RISE_EDGE_OUT & RISE_EN) | (FALL_EDGE_OUT & FALL_EN).
  - Set takes effect on the next edge.
  - EVENT_CLEAR clears the flag on the next edge.
  - Set and clear in the same cycle: set wins, flag stays 1.
  - Enables gate only the pending flags, never the edge pulses or LEVEL_OUT.
- IRQ_OUT is combinational OR of the EVENT_PENDING flops.
- Channels are fully independent; simultaneous events on all channels are all captured.
- After reset release with SAMPLE_IN[i]=1, channel i produces a rise pulse after the normal latency, because level resets to 0.

Optional Feature:
EDGE_DET_EVENT_CNT_EN
- Defined:
  - Adds output EVENT_CNT_OUT, NUM_CH*CNT_W wide; channel i occupies bits [i*CNT_W +: CNT_W].
  - Each channel counter increments when that channel's pending set condition is true, and saturates at 2^CNT_W-1.
  - EVENT_CLEAR[i] resets counter i to 0. Clear together with an increment gives 1.
  - Reset value 0.
- Not defined: the port and counters are absent, and all other behaviour is unchanged.

Test Plan:
1. Hold RSTN=0 with SAMPLE_IN=8'hFF, then release; RISE_EN=8'hFF -> all outputs 0 during reset; RISE_EDGE_OUT=8'hFF for 1 cycle after edge 6; EVENT_PENDING=8'hFF and IRQ_OUT=1 one cycle later.
2. Defaults, SAMPLE_IN[0] 0->1 held -> LEVEL_OUT[0]=1 and a single RISE_EDGE_OUT[0] pulse after edge 6; FALL_EDGE_OUT=0; other channels unaffected. Then 1->0 -> single FALL_EDGE_OUT[0] pulse with the same latency.
3. SAMPLE_IN[1] high for 3 cycles -> no pulse, LEVEL_OUT[1]=0. High for 4 cycles -> rise pulse, then fall pulse 4 cycles after the rise.
4. RISE_EN[2]=0, FALL_EN[2]=1, toggle input -> both pulses seen, EVENT_PENDING[2] set only by the fall. Assert EVENT_CLEAR[2] in the cycle of a new fall pulse -> EVENT_PENDING[2] remains 1; a later clear alone -> 0, IRQ_OUT=0.
5. Assert RSTN=0 asynchronously, mid-clock, while the channel 3 counter is at 2 -> outputs 0 immediately, before the next CLK edge. Release with SAMPLE_IN[3]=0 -> no pulse ever.
6. With EDGE_DET_EVENT_CNT_EN and CNT_W=8, apply 300 enabled rise events on channel 4 -> EVENT_CNT_OUT[39:32]=255. Then EVENT_CLEAR[4] -> 0.

Source files
------------

// File: rtl/edge_detector_mc.sv
// Multi-channel edge detector: per-channel synchroniser, stability filter, rise/fall pulses and sticky event flags.
// Optional per-channel saturating event counters are built when EDGE_DET_EVENT_CNT_EN is defined.
module edge_detector_mc #(
  parameter int NUM_CH        = 8,
  parameter int SYNC_STAGES   = 2,
  parameter int FILTER_CYCLES = 4,
  parameter int CNT_W         = 8
) (
  input  logic                    CLK,
  input  logic                    RSTN,
  input  logic [NUM_CH-1:0]       SAMPLE_IN,
  input  logic [NUM_CH-1:0]       RISE_EN,
  input  logic [NUM_CH-1:0]       FALL_EN,
  input  logic [NUM_CH-1:0]       EVENT_CLEAR,
  output logic [NUM_CH-1:0]       LEVEL_OUT,
  output logic [NUM_CH-1:0]       RISE_EDGE_OUT,
  output logic [NUM_CH-1:0]       FALL_EDGE_OUT,
  output logic [NUM_CH-1:0]       EVENT_PENDING,
  output logic                    IRQ_OUT
`ifdef EDGE_DET_EVENT_CNT_EN
  ,
  output logic [NUM_CH*CNT_W-1:0] EVENT_CNT_OUT
`endif
);

  localparam int FW = (FILTER_CYCLES > 1) ? $clog2(FILTER_CYCLES) : 1;
  localparam logic [FW-1:0] FILT_LAST = FW'(FILTER_CYCLES - 1);

  logic [SYNC_STAGES-1:0][NUM_CH-1:0] sync_q, sync_d;
  logic [NUM_CH-1:0][FW-1:0]          fcnt_q, fcnt_d;
  logic [NUM_CH-1:0]                  level_q, level_d;
  logic [NUM_CH-1:0]                  prev_q, prev_d;
  logic [NUM_CH-1:0]                  pend_q, pend_d;
  logic [NUM_CH-1:0]                  sync_last;
  logic [NUM_CH-1:0]                  rise, fall, set_evt;

  always_comb begin
    sync_d    = sync_q;
    sync_d[0] = SAMPLE_IN;
    for (int s = 1; s < SYNC_STAGES; s++) begin
      sync_d[s] = sync_q[s-1];
    end
  end

  assign sync_last = sync_q[SYNC_STAGES-1];

  // Level only moves after the synchronised value has disagreed for FILTER_CYCLES consecutive cycles.
  always_comb begin
    fcnt_d  = fcnt_q;
    level_d = level_q;
    for (int i = 0; i < NUM_CH; i++) begin
      if (sync_last[i] == level_q[i]) begin
        fcnt_d[i] = '0;
      end else if (fcnt_q[i] == FILT_LAST) begin
        level_d[i] = sync_last[i];
        fcnt_d[i]  = '0;
      end else begin
        fcnt_d[i] = fcnt_q[i] + FW'(1);
      end
    end
  end

  assign prev_d  = level_q;
  assign rise    = level_q & ~prev_q;
  assign fall    = ~level_q & prev_q;
  assign set_evt = (rise & RISE_EN) | (fall & FALL_EN);

  // A set in the same cycle as a clear keeps the flag.
  assign pend_d = set_evt | (pend_q & ~EVENT_CLEAR);

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      sync_q  <= '0;
      fcnt_q  <= '0;
      level_q <= '0;
      prev_q  <= '0;
      pend_q  <= '0;
    end else begin
      sync_q  <= sync_d;
      fcnt_q  <= fcnt_d;
      level_q <= level_d;
      prev_q  <= prev_d;
      pend_q  <= pend_d;
    end
  end

  assign LEVEL_OUT     = level_q;
  assign RISE_EDGE_OUT = rise;
  assign FALL_EDGE_OUT = fall;
  assign EVENT_PENDING = pend_q;
  assign IRQ_OUT       = |pend_q;

`ifdef EDGE_DET_EVENT_CNT_EN
  logic [NUM_CH-1:0][CNT_W-1:0] ecnt_q, ecnt_d;

  // Clear wins over the old count but a coincident event still counts as one.
  always_comb begin
    ecnt_d = ecnt_q;
    for (int i = 0; i < NUM_CH; i++) begin
      if (EVENT_CLEAR[i]) begin
        ecnt_d[i] = set_evt[i] ? CNT_W'(1) : '0;
      end else if (set_evt[i] && (ecnt_q[i] != {CNT_W{1'b1}})) begin
        ecnt_d[i] = ecnt_q[i] + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      ecnt_q <= '0;
    end else begin
      ecnt_q <= ecnt_d;
    end
  end

  assign EVENT_CNT_OUT = ecnt_q;
`else
  logic unused_cnt_w;
  assign unused_cnt_w = ^CNT_W;
`endif

endmodule
